// File: rtl/ysyx_24080014_ifu.sv
// ysyx_24080014_ifu - instruction fetch unit.
// Issues one read per instruction on a valid/ready read channel, keeps the
// fetched word until decode accepts it, then strobes pc_ready_o so the PC
// register advances. Only one instruction is in flight at a time.
//
// Optional feature: define YSYX_24080014_IFU_MISALIGN_CHK_EN to enable the
// misaligned-PC check. A PC with pc[1:0] != 0 then skips the bus and is
// delivered straight to HOLD as a NOP with fault code 2.
module ysyx_24080014_ifu #(
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic [31:0] pc_i,
    output logic        pc_ready_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [1:0]  fault_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_ACCESS   = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [1:0]  fault_q, fault_d;
    logic        misaligned;

`ifdef YSYX_24080014_IFU_MISALIGN_CHK_EN
    assign misaligned = (pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // State and delivered-instruction registers; reset parks the unit idle with a NOP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            inst_q    <= RESET_INST;
            inst_pc_q <= 32'h0;
            fault_q   <= FAULT_NONE;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state logic: walk IDLE/ADDR/DATA/HOLD, capturing PC on the address handshake and data on the read handshake.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_en_i) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (misaligned) begin
                    inst_pc_d = pc_i;
                    inst_d    = RESET_INST;
                    fault_d   = FAULT_MISALIGN;
                    state_d   = HOLD;
                end else if (arready_i) begin
                    inst_pc_d = pc_i;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (rvalid_i) begin
                    if (rresp_i != 2'b00) begin
                        inst_d  = RESET_INST;
                        fault_d = FAULT_ACCESS;
                    end else begin
                        inst_d  = rdata_i;
                        fault_d = FAULT_NONE;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = fetch_en_i ? ADDR : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the state alone so an async reset clears them in the same cycle.
    always_comb begin
        arvalid_o   = (state_q == ADDR) && !misaligned;
        rready_o    = (state_q == DATA);
        out_valid_o = (state_q == HOLD);
        pc_ready_o  = (state_q == HOLD) && out_ready_i;
    end

    assign araddr_o  = pc_i;
    assign inst_o    = inst_q;
    assign inst_pc_o = inst_pc_q;
    assign fault_o   = fault_q;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// tb_ysyx_24080014_ifu - directed self-checking bench for the fetch unit.
// Expected values are hand-computed from the fetch protocol; the memory side
// is driven directly from the bench.
module tb_ysyx_24080014_ifu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_en_i;
    logic [31:0] pc_i;
    logic        pc_ready_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [1:0]  fault_o;

    int testCount = 0;
    int failCount = 0;

    ysyx_24080014_ifu #(.RESET_INST(32'h0000_0013)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_en_i  (fetch_en_i),
        .pc_i        (pc_i),
        .pc_ready_o  (pc_ready_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .araddr_o    (araddr_o),
        .rvalid_i    (rvalid_i),
        .rready_o    (rready_o),
        .rdata_i     (rdata_i),
        .rresp_i     (rresp_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_o      (inst_o),
        .inst_pc_o   (inst_pc_o),
        .fault_o     (fault_o)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock and land 2 ns after the rising edge.
    task automatic applyStimulus();
        @(posedge clk_i);
        #2;
    endtask

    int arCycles;
    int rCycles;
    int pcReadyCount;
    int addrWaits;
    int dataWaits;
    int unstable;
    logic [31:0] firstAddr;

    initial begin
        rst_i       = 1'b1;
        fetch_en_i  = 1'b0;
        pc_i        = 32'h8000_0000;
        arready_i   = 1'b0;
        rvalid_i    = 1'b0;
        rdata_i     = 32'h0;
        rresp_i     = 2'b00;
        out_ready_i = 1'b1;

        // ---- Reset values ----
        applyStimulus();
        applyStimulus();
        checkOutput("rst_arvalid",  {31'b0, arvalid_o},   32'd0);
        checkOutput("rst_rready",   {31'b0, rready_o},    32'd0);
        checkOutput("rst_outvalid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("rst_pcready",  {31'b0, pc_ready_o},  32'd0);
        checkOutput("rst_inst",     inst_o,               32'h0000_0013);
        checkOutput("rst_instpc",   inst_pc_o,            32'h0);
        checkOutput("rst_fault",    {30'b0, fault_o},     32'd0);
        rst_i = 1'b0;

        // ---- Best-case fetch, zero-wait memory ----
        fetch_en_i = 1'b1;
        arready_i  = 1'b1;
        rvalid_i   = 1'b1;
        rdata_i    = 32'h0010_0093;
        applyStimulus();                       // cycle 1: ADDR
        checkOutput("bc_arvalid", {31'b0, arvalid_o}, 32'd1);
        checkOutput("bc_araddr",  araddr_o,           32'h8000_0000);
        checkOutput("bc_rready0", {31'b0, rready_o},  32'd0);
        applyStimulus();                       // cycle 2: DATA
        checkOutput("bc_rready",  {31'b0, rready_o},  32'd1);
        checkOutput("bc_arvalid0",{31'b0, arvalid_o}, 32'd0);
        applyStimulus();                       // cycle 3: HOLD
        checkOutput("bc_outvalid",{31'b0, out_valid_o}, 32'd1);
        checkOutput("bc_inst",    inst_o,               32'h0010_0093);
        checkOutput("bc_instpc",  inst_pc_o,            32'h8000_0000);
        checkOutput("bc_pcready", {31'b0, pc_ready_o},  32'd1);
        checkOutput("bc_fault",   {30'b0, fault_o},     32'd0);
        fetch_en_i = 1'b0;
        applyStimulus();                       // back to IDLE
        checkOutput("bc_idle_ov", {31'b0, out_valid_o}, 32'd0);
        checkOutput("bc_idle_ar", {31'b0, arvalid_o},   32'd0);

        // ---- Delayed arready (3 cycles) and rvalid (2 cycles) ----
        pc_i         = 32'h8000_0004;
        rdata_i      = 32'h0020_0113;
        arready_i    = 1'b0;
        rvalid_i     = 1'b0;
        fetch_en_i   = 1'b1;
        arCycles     = 0;
        rCycles      = 0;
        pcReadyCount = 0;
        addrWaits    = 0;
        dataWaits    = 0;
        unstable     = 0;
        firstAddr    = 32'h0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk_i);
            #1;
            if (arvalid_o) begin
                fetch_en_i = 1'b0;
                arready_i  = (addrWaits == 3);
                addrWaits++;
            end else begin
                arready_i = 1'b0;
            end
            if (rready_o) begin
                rvalid_i = (dataWaits == 2);
                dataWaits++;
            end else begin
                rvalid_i = 1'b0;
            end
            #1;
            if (arvalid_o) begin
                if (arCycles == 0) firstAddr = araddr_o;
                else if (araddr_o != firstAddr) unstable++;
                arCycles++;
            end
            if (rready_o) rCycles++;
            if (pc_ready_o) pcReadyCount++;
        end
        checkOutput("dly_arcycles", arCycles,     32'd4);
        checkOutput("dly_araddr",   firstAddr,    32'h8000_0004);
        checkOutput("dly_addrstab", unstable,     32'd0);
        checkOutput("dly_rcycles",  rCycles,      32'd3);
        checkOutput("dly_pcready",  pcReadyCount, 32'd1);
        checkOutput("dly_inst",     inst_o,       32'h0020_0113);
        checkOutput("dly_instpc",   inst_pc_o,    32'h8000_0004);

        // ---- Decode back-pressure for 5 HOLD cycles ----
        pc_i        = 32'h8000_0008;
        rdata_i     = 32'h0030_0193;
        arready_i   = 1'b1;
        rvalid_i    = 1'b1;
        out_ready_i = 1'b0;
        fetch_en_i  = 1'b1;
        applyStimulus();                       // ADDR
        applyStimulus();                       // DATA
        unstable     = 0;
        pcReadyCount = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus();                   // HOLD, stalled
            if (!out_valid_o) unstable++;
            if (inst_o != 32'h0030_0193) unstable++;
            if (inst_pc_o != 32'h8000_0008) unstable++;
            if (pc_ready_o) pcReadyCount++;
        end
        checkOutput("bp_stable",   unstable,     32'd0);
        checkOutput("bp_nopcrdy",  pcReadyCount, 32'd0);
        out_ready_i = 1'b1;
        #1;
        checkOutput("bp_pcready",  {31'b0, pc_ready_o}, 32'd1);
        pc_i = 32'h8000_000C;
        rdata_i = 32'h0040_0213;
        applyStimulus();                       // next fetch: ADDR
        checkOutput("bp_next_ar",  {31'b0, arvalid_o},  32'd1);
        checkOutput("bp_next_pcr", {31'b0, pc_ready_o}, 32'd0);
        checkOutput("bp_next_addr", araddr_o,           32'h8000_000C);
        fetch_en_i = 1'b0;
        applyStimulus();                       // DATA
        applyStimulus();                       // HOLD
        checkOutput("bp_next_inst", inst_o, 32'h0040_0213);
        applyStimulus();                       // IDLE

        // ---- Access error response ----
        pc_i       = 32'h8000_0010;
        rdata_i    = 32'hDEAD_BEEF;
        rresp_i    = 2'b10;
        fetch_en_i = 1'b1;
        applyStimulus();                       // ADDR
        fetch_en_i = 1'b0;
        applyStimulus();                       // DATA
        applyStimulus();                       // HOLD
        checkOutput("err_fault",   {30'b0, fault_o},     32'd1);
        checkOutput("err_inst",    inst_o,               32'h0000_0013);
        checkOutput("err_instpc",  inst_pc_o,            32'h8000_0010);
        checkOutput("err_pcready", {31'b0, pc_ready_o},  32'd1);
        applyStimulus();                       // IDLE
        checkOutput("err_idle",    {31'b0, out_valid_o}, 32'd0);
        rresp_i = 2'b00;

        // ---- Misaligned PC ----
        pc_i       = 32'h8000_0002;
        rdata_i    = 32'h0050_0293;
        fetch_en_i = 1'b1;
        applyStimulus();                       // ADDR
        fetch_en_i = 1'b0;
`ifdef YSYX_24080014_IFU_MISALIGN_CHK_EN
        checkOutput("mis_noar",    {31'b0, arvalid_o},   32'd0);
        applyStimulus();                       // HOLD
        checkOutput("mis_hold",    {31'b0, out_valid_o}, 32'd1);
        checkOutput("mis_fault",   {30'b0, fault_o},     32'd2);
        checkOutput("mis_inst",    inst_o,               32'h0000_0013);
        checkOutput("mis_instpc",  inst_pc_o,            32'h8000_0002);
`else
        checkOutput("mis_ar",      {31'b0, arvalid_o},   32'd1);
        checkOutput("mis_araddr",  araddr_o,             32'h8000_0002);
        applyStimulus();                       // DATA
        applyStimulus();                       // HOLD
        checkOutput("mis_hold",    {31'b0, out_valid_o}, 32'd1);
        checkOutput("mis_fault",   {30'b0, fault_o},     32'd0);
        checkOutput("mis_inst",    inst_o,               32'h0050_0293);
`endif
        applyStimulus();                       // IDLE

        // ---- Asynchronous reset in the middle of DATA ----
        pc_i       = 32'h8000_0014;
        rvalid_i   = 1'b0;
        fetch_en_i = 1'b1;
        applyStimulus();                       // ADDR
        applyStimulus();                       // DATA, waiting on rvalid
        checkOutput("ar_rready_pre", {31'b0, rready_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("ar_rready",   {31'b0, rready_o},    32'd0);
        checkOutput("ar_outvalid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("ar_arvalid",  {31'b0, arvalid_o},   32'd0);
        checkOutput("ar_inst",     inst_o,               32'h0000_0013);
        checkOutput("ar_instpc",   inst_pc_o,            32'h0);
        pc_i = 32'h8000_0020;
        #1;
        rst_i = 1'b0;
        applyStimulus();                       // restart: ADDR
        checkOutput("ar_restart",  {31'b0, arvalid_o},   32'd1);
        checkOutput("ar_newaddr",  araddr_o,             32'h8000_0020);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
